// File: rtl/ct_spsram_64x108_ctrl_if.sv
`default_nettype none
// ============================================================================
// ct_spsram_64x108_ctrl_if : request/response bus of the 64x108 SRAM controller
// Revision: 1.0
// ============================================================================
interface ct_spsram_64x108_ctrl_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 108,
   parameter int BANK_WIDTH = 27
);
   localparam int NUM_BANKS = DATA_WIDTH / BANK_WIDTH;

   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_wen;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [NUM_BANKS-1:0]  req_bwe;
   logic                  rsp_vld;
   logic                  rsp_rdy;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_vld, req_wen, req_addr, req_wdata, req_bwe, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_data
   );

   modport slave (
      input  req_vld, req_wen, req_addr, req_wdata, req_bwe, rsp_rdy,
      output req_rdy, rsp_vld, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/ct_spsram_64x108_ctrl.sv
`default_nettype none
// ============================================================================
// ct_spsram_64x108_ctrl : valid/ready controller for a 64x108 single-port SRAM
// Revision: 1.0
// ============================================================================
module ct_spsram_64x108_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 108,
   parameter int BANK_WIDTH = 27
) (
   input  wire logic                  forever_cpuclk,
   input  wire logic                  cpurst_b,
   input  wire logic                  clr_req,
   output logic                       init_done,
   ct_spsram_64x108_ctrl_if.slave     bus,
   output logic                       sram_cen,
   output logic                       sram_gwen,
   output logic [DATA_WIDTH-1:0]      sram_wen,
   output logic [ADDR_WIDTH-1:0]      sram_a,
   output logic [DATA_WIDTH-1:0]      sram_d,
   input  wire logic [DATA_WIDTH-1:0] sram_q
);
   localparam int NUM_BANKS = DATA_WIDTH / BANK_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
   logic                  clr_pend, clr_pend_nxt;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            buf_cnt;
   logic [1:0]            used;
   logic                  run_rdy, accept, push, pop;
   logic [DATA_WIDTH-1:0] bwe_mask;

   genvar k;
   generate
      for (k = 0; k < NUM_BANKS; k++) begin : g_bwe
         assign bwe_mask[k*BANK_WIDTH +: BANK_WIDTH] = {BANK_WIDTH{bus.req_bwe[k]}};
      end
   endgenerate

   // A credit covers both a read in flight to the macro and a buffered response
   assign used      = buf_cnt + {1'b0, rd_pend};
   assign run_rdy   = (state == ST_RUN) && (used < 2'd2) && !clr_req && !clr_pend;
   assign accept    = run_rdy && bus.req_vld;
   assign push      = rd_pend;
   assign pop       = bus.rsp_vld && bus.rsp_rdy;

   assign init_done    = (state == ST_RUN);
   assign bus.req_rdy  = run_rdy;
   assign bus.rsp_vld  = (buf_cnt != 2'd0);
   assign bus.rsp_data = buf_mem[rd_ptr];

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      clr_pend_nxt = clr_pend;
      sram_cen     = 1'b1;
      sram_gwen    = 1'b1;
      sram_wen     = '1;
      sram_a       = '0;
      sram_d       = '0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_INIT;
         end
         ST_INIT: begin
            sram_cen     = 1'b0;
            sram_gwen    = 1'b0;
            sram_wen     = '0;
            sram_a       = init_cnt;
            init_cnt_nxt = init_cnt + 1'b1;
            if (init_cnt == '1) begin
               state_nxt    = ST_RUN;
               init_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               sram_cen = 1'b0;
               sram_a   = bus.req_addr;
               if (bus.req_wen) begin
                  sram_gwen = 1'b0;
                  sram_d    = bus.req_wdata;
                  sram_wen  = ~bwe_mask;
               end
            end
            // A clear seen while a read is in flight waits for that capture first
            if (clr_pend) begin
               state_nxt    = ST_INIT;
               clr_pend_nxt = 1'b0;
            end else if (clr_req) begin
               if (rd_pend) clr_pend_nxt = 1'b1;
               else         state_nxt    = ST_INIT;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state      <= ST_IDLE;
         init_cnt   <= '0;
         clr_pend   <= 1'b0;
         rd_pend    <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         buf_cnt    <= 2'd0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
         clr_pend <= clr_pend_nxt;
         rd_pend  <= accept && !bus.req_wen;
         if (push) begin
            buf_mem[wr_ptr] <= sram_q;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/ct_spsram_64x108_ctrl.md
Name: ct_spsram_64x108_ctrl

Overview:
- Initiator/controller for a 64x108 single-port SRAM macro with active-low CEN/GWEN/WEN.
- Converts a valid/ready request stream into macro accesses and captures read data into a 2-entry response buffer with backpressure.
- Zero-initialises all 64 entries after reset and on request.
- Sits between a cache/buffer pipeline and the SRAM macro, and drives all macro inputs.

Parameters:
- ADDR_WIDTH, 6, macro address width (depth = 2^ADDR_WIDTH = 64)
- DATA_WIDTH, 108, macro data width
- BANK_WIDTH, 27, bits per write-enable bank (DATA_WIDTH/BANK_WIDTH = 4 banks)

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- clr_req  in  1  pulse: re-run zero-initialisation
- init_done  out  1  high when in RUN state
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld&&req_rdy at posedge
- req_wen  in  1  1=write, 0=read
- req_addr  in  6  entry address
- req_wdata  in  108  write data
- req_bwe  in  4  per-bank write enable, active-high; bank k = bits [27k+26:27k]
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  consumer ready
- rsp_data  out  108  read data
- sram_cen  out  1  macro chip enable, active-low
- sram_gwen  out  1  macro global write enable, active-low
- sram_wen  out  108  macro bit write enable, active-low
- sram_a  out  6  macro address
- sram_d  out  108  macro write data
- sram_q  in  108  macro read data, valid the cycle after a read access

Behaviour:
- FSM states IDLE, INIT, RUN. Reset value is IDLE, init_cnt=0, buffer empty, rd_pend=0.
- IDLE -> INIT unconditionally on the next edge.
- Reset values of outputs:
  - init_done=0, req_rdy=0, rsp_vld=0, rsp_data=0.
  - sram_cen=1, sram_gwen=1, sram_wen all 1, sram_a=0, sram_d=0.
- Macro outputs are combinational from state and request. The macro samples them at posedge.
- INIT:
  - sram_cen=0, sram_gwen=0, sram_wen all 0, sram_a=init_cnt, sram_d=0.
  - init_cnt increments each cycle. At init_cnt=63, go to RUN, reset init_cnt=0.
  - Takes exactly 64 cycles.
  - req_rdy=0 throughout. clr_req is ignored in INIT.
- RUN:
  - init_done=1.
  - req_rdy = (buf_cnt + rd_pend < 2) && !clr_req.
  - On acceptance: sram_cen=0, sram_a=req_addr.
  - Write:
    - sram_gwen=0, sram_d=req_wdata.
    - sram_wen bank k = {27{~req_bwe[k]}}.
    - req_bwe=0 is legal: access with all WEN high, no data change.
  - Read: sram_gwen=1, sram_wen all 1. Set rd_pend=1.
  - No acceptance: sram_cen=1, sram_gwen=1, sram_wen all 1. sram_a and sram_d hold 0.
- Read latency:
  - Read accepted at edge E. sram_q is sampled at edge E+1 into the buffer tail, and rd_pend clears.
  - rsp_vld=1 after E+1, so minimum latency is 2 cycles.
  - Back-to-back reads are allowed while credits permit. rd_pend and a new acceptance may overlap; the credit rule prevents overflow.
- Response buffer:
  - 2-entry FIFO, in order. rsp_data = head entry. Pop on rsp_vld&&rsp_rdy.
  - Simultaneous push and pop keeps buf_cnt unchanged.
  - rsp_rdy low indefinitely: at most 2 reads are outstanding or buffered, and req_rdy drops.
- Ordering: the single port gives strict request order. A read after a write to the same address returns the new data.
- clr_req in RUN:
  - Sampled at posedge. If rd_pend=0, go to INIT next cycle.
  - If rd_pend=1, go to INIT after the pending capture; a registered clr_pend flag holds the request.
  - Buffered responses are retained and still drain during INIT.
- Reset asserted mid-operation: all state returns to reset values immediately. A buffered response is lost; a partial INIT restarts from entry 0.

Test Plan:
1. Release reset:
   - IDLE for 1 cycle, then 64 cycles of sram_cen=0, sram_gwen=0, sram_a=0..63, sram_d=0.
   - init_done=1 on cycle 66; after it, reading any address returns 0.
2. Write addr 5, data 0x123...ABC, bwe=4'b1111, then read addr 5 back-to-back:
   - sram_gwen=0 then 1.
   - rsp_vld 2 cycles after the read is accepted, rsp_data = written value.
3. Write addr 9 all-ones with bwe=4'b0101 over a zeroed entry, then read:
   - rsp_data bits [26:0] and [80:54] are ones; bits [53:27] and [107:81] are zero.
4. Hold rsp_rdy=0 and issue 3 reads (addr 1, 2, 3):
   - First two accepted, req_rdy=0 for the third.
   - Raise rsp_rdy: data returns in order 1, 2, 3; no loss or duplication.
5. Pulse clr_req in the same cycle a read is accepted:
   - That read is not accepted (req_rdy=0).
   - A read accepted one cycle earlier is still returned.
   - INIT runs 64 cycles; afterwards all entries read 0.
6. Assert cpurst_b low at INIT entry 30:
   - Outputs go to reset values asynchronously.
   - After release, INIT restarts at sram_a=0 and completes 64 writes.
